// File: rtl/rate_tick_generator.sv
// Rate-selectable tick source feeding the counter's enable input.
// Run/pause, single-step and rate_sel are synchronised and edge-detected here.
module rate_tick_generator #(
    parameter int unsigned BASE_COUNT = 50000000,
    parameter int unsigned CNT_W      = 28
) (
    input  logic       clock,
    input  logic       clear_b,
    input  logic       run_toggle,
    input  logic       step,
    input  logic [1:0] rate_sel,
    output logic       tick,
    output logic       running
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    logic             tog_s1_q, tog_s2_q, tog_prev_q;
    logic             step_s1_q, step_s2_q, step_prev_q;
    logic [1:0]       rate_s1_q, rate_s2_q, rate_prev_q;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             tick_q;
    logic             resume_q;
    logic             running_q;

    logic             tog_edge;
    logic             step_edge;
    logic             rate_chg;
    logic             load_resume;
    logic [CNT_W-1:0] reload;

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            tog_s1_q    <= 1'b0;
            tog_s2_q    <= 1'b0;
            tog_prev_q  <= 1'b0;
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
            step_prev_q <= 1'b0;
            rate_s1_q   <= '0;
            rate_s2_q   <= '0;
            rate_prev_q <= '0;
        end else begin
            tog_s1_q    <= run_toggle;
            tog_s2_q    <= tog_s1_q;
            tog_prev_q  <= tog_s2_q;
            step_s1_q   <= step;
            step_s2_q   <= step_s1_q;
            step_prev_q <= step_s2_q;
            rate_s1_q   <= rate_sel;
            rate_s2_q   <= rate_s1_q;
            rate_prev_q <= rate_s2_q;
        end
    end

    assign tog_edge    = tog_s2_q & ~tog_prev_q;
    assign step_edge   = step_s2_q & ~step_prev_q;
    assign rate_chg    = (rate_s2_q != rate_prev_q);
    // A toggle seen while loading flips resume before it picks the next state.
    assign load_resume = resume_q ^ tog_edge;

    always_comb begin
        reload = '0;
        case (rate_s2_q)
            2'b00:   reload = '0;
            2'b01:   reload = CNT_W'(BASE_COUNT - 1);
            2'b10:   reload = CNT_W'(2 * BASE_COUNT - 1);
            default: reload = CNT_W'(4 * BASE_COUNT - 1);
        endcase
    end

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state_q   <= S_LOAD;
            count_q   <= '0;
            tick_q    <= 1'b0;
            resume_q  <= 1'b1;
            running_q <= 1'b1;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    count_q   <= reload;
                    resume_q  <= load_resume;
                    running_q <= load_resume;
                    state_q   <= load_resume ? S_RUN : S_PAUSE;
                end
                S_RUN: begin
                    if (rate_chg) begin
                        state_q   <= S_LOAD;
                        resume_q  <= ~tog_edge;
                        running_q <= ~tog_edge;
                    end else if (tog_edge) begin
                        state_q   <= S_PAUSE;
                        resume_q  <= 1'b0;
                        running_q <= 1'b0;
                    end else if (count_q == '0) begin
                        tick_q  <= 1'b1;
                        count_q <= reload;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (rate_chg) begin
                        state_q   <= S_LOAD;
                        resume_q  <= tog_edge;
                        running_q <= tog_edge;
                    end else if (tog_edge) begin
                        state_q   <= S_RUN;
                        resume_q  <= 1'b1;
                        running_q <= 1'b1;
                    end else if (step_edge) begin
                        tick_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_LOAD;
                    resume_q  <= 1'b1;
                    running_q <= 1'b1;
                end
            endcase
        end
    end

    assign tick    = tick_q;
    assign running = running_q;

endmodule
